// File: rtl/mem_io_responder.sv
// Responder for the CPU byte-wide memory bus: RAM, I/O window (RX/TX FIFOs,
// cycle counter with snapshot, finish flag) and TX back-pressure via cpu_rdy.
module mem_io_responder #(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        cpu_rdy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_finish
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_XOR   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] RDY_MAX_CNT = (FIFO_AW+1)'(DEPTH - 2);

  logic [7:0]         r_ram [0:(1<<RAM_AW)-1];
  logic [7:0]         r_rx_mem [0:DEPTH-1];
  logic [7:0]         r_tx_mem [0:DEPTH-1];
  logic [FIFO_AW:0]   r_rx_wptr, r_rx_rptr;
  logic [FIFO_AW:0]   r_tx_wptr, r_tx_rptr;
  logic [31:0]        r_cycle_cnt;
  logic [31:0]        r_snapshot;
  logic [7:0]         r_din;
  logic               r_finish;

  logic               w_sel_ram, w_sel_io;
  logic               w_io_data, w_io_cnt0, w_io_cnt1, w_io_cnt2, w_io_cnt3;
  logic               w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic               w_rx_push, w_rx_pop, w_tx_push_req, w_tx_push, w_tx_pop;
  logic [FIFO_AW:0]   w_tx_count;
  logic [7:0]         w_rd_data;
  logic               w_unused;

  assign w_unused = ^mem_a[31:18];

  // Address decode on mem_a[17:0]
  assign w_sel_ram = (mem_a[17] == 1'b0);
  assign w_sel_io  = (mem_a[17:16] == 2'b11);
  assign w_io_data = w_sel_io && (mem_a[15:0] == 16'h0000);
  assign w_io_cnt0 = w_sel_io && (mem_a[15:0] == 16'h0004);
  assign w_io_cnt1 = w_sel_io && (mem_a[15:0] == 16'h0005);
  assign w_io_cnt2 = w_sel_io && (mem_a[15:0] == 16'h0006);
  assign w_io_cnt3 = w_sel_io && (mem_a[15:0] == 16'h0007);

  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = ((r_rx_wptr ^ r_rx_rptr) == FULL_XOR);
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = ((r_tx_wptr ^ r_tx_rptr) == FULL_XOR);
  assign w_tx_count = r_tx_wptr - r_tx_rptr;

  assign rx_ready       = !w_rx_full;
  assign tx_valid       = !w_tx_empty;
  assign tx_data        = r_tx_mem[r_tx_rptr[FIFO_AW-1:0]];
  assign cpu_rdy        = (w_tx_count <= RDY_MAX_CNT);
  assign mem_din        = r_din;
  assign program_finish = r_finish;

  // An empty RX FIFO is never popped, so a same-cycle host push still lands
  assign w_rx_push     = !rst_in && rx_valid && rx_ready;
  assign w_rx_pop      = !rst_in && !mem_wr && w_io_data && !w_rx_empty;
  assign w_tx_push_req = !rst_in && mem_wr &&
                         ((w_io_data && (mem_dout != 8'h00)) || w_io_cnt0);
  assign w_tx_push     = w_tx_push_req && !w_tx_full;
  assign w_tx_pop      = !rst_in && tx_valid && tx_ready;

  always_comb begin
    w_rd_data = 8'h00;
    if (w_sel_ram) begin
      w_rd_data = r_ram[mem_a[RAM_AW-1:0]];
    end else if (w_io_data) begin
      w_rd_data = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[FIFO_AW-1:0]];
    end else if (w_io_cnt0) begin
      w_rd_data = r_cycle_cnt[7:0];
    end else if (w_io_cnt1) begin
      w_rd_data = r_snapshot[15:8];
    end else if (w_io_cnt2) begin
      w_rd_data = r_snapshot[23:16];
    end else if (w_io_cnt3) begin
      w_rd_data = r_snapshot[31:24];
    end
  end

  // RAM is deliberately not reset
  always_ff @(posedge clk_in) begin
    if (!rst_in && mem_wr && w_sel_ram) begin
      r_ram[mem_a[RAM_AW-1:0]] <= mem_dout;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_din <= 8'h00;
    end else begin
      r_din <= mem_wr ? 8'h00 : w_rd_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cycle_cnt <= 32'h0;
      r_snapshot  <= 32'h0;
      r_finish    <= 1'b0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'h1;
      if (!mem_wr && w_io_cnt0) begin
        r_snapshot <= r_cycle_cnt;
      end
      if (mem_wr && w_io_cnt0) begin
        r_finish <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wptr[FIFO_AW-1:0]] <= rx_data;
    end
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr[FIFO_AW-1:0]] <= w_io_cnt0 ? 8'h00 : mem_dout;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: vector table plus hand-written
// sequences for back-pressure, RX full, counter snapshot/wrap and reset.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        cpu_rdy;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_finish;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .cpu_rdy(cpu_rdy),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .program_finish(program_finish)
  );

  always #5 clk_in = ~clk_in;

  // A TX push into a full FIFO must never be requested
  always @(posedge clk_in) begin
    if (!rst_in && dut.w_tx_push_req && dut.w_tx_full) begin
      n_fail++;
      $display("FAIL tx_overflow: push requested while TX full at %0t", $time);
    end
  end

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic        chk_din;
    logic [7:0]  din;
    logic        rdy;
    logic        rxr;
    logic        txv;
    logic [7:0]  txd;
    logic        fin;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic [31:0] a, logic wr, logic [7:0] dout,
                              logic rxv, logic [7:0] rxd, logic txr,
                              logic chk_din, logic [7:0] din, logic txv,
                              logic [7:0] txd, logic fin);
    vec_t v;
    v.a = a; v.wr = wr; v.dout = dout; v.rxv = rxv; v.rxd = rxd; v.txr = txr;
    v.chk_din = chk_din; v.din = din; v.rdy = 1'b1; v.rxr = 1'b1;
    v.txv = txv; v.txd = txd; v.fin = fin;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a = a; mem_wr = wr; mem_dout = d;
  endtask

  int          drained;
  logic [7:0]  exp_tx;
  logic [31:0] assembled;

  initial begin
    rst_in = 1'b1; mem_a = 0; mem_wr = 0; mem_dout = 0;
    rx_valid = 0; rx_data = 0; tx_ready = 0;

    vecs[0]  = mk(32'h00010, 1, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    vecs[1]  = mk(32'h00010, 0, 8'h00, 0, 8'h00, 0, 1, 8'hA5, 0, 8'h00, 0);
    vecs[2]  = mk(32'h20010, 1, 8'h5A, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    vecs[3]  = mk(32'h00010, 0, 8'h00, 0, 8'h00, 0, 1, 8'hA5, 0, 8'h00, 0);
    vecs[4]  = mk(32'h20010, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0);
    vecs[5]  = mk(32'h1FFFF, 1, 8'h3C, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    vecs[6]  = mk(32'h1FFFF, 0, 8'h00, 0, 8'h00, 0, 1, 8'h3C, 0, 8'h00, 0);
    vecs[7]  = mk(32'h1FFFF, 0, 8'h00, 1, 8'h41, 0, 1, 8'h3C, 0, 8'h00, 0);
    vecs[8]  = mk(32'h00010, 0, 8'h00, 1, 8'h42, 0, 1, 8'hA5, 0, 8'h00, 0);
    vecs[9]  = mk(32'h30000, 0, 8'h00, 0, 8'h00, 0, 1, 8'h41, 0, 8'h00, 0);
    vecs[10] = mk(32'h30000, 0, 8'h00, 0, 8'h00, 0, 1, 8'h42, 0, 8'h00, 0);
    vecs[11] = mk(32'h30000, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0);
    vecs[12] = mk(32'h30000, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0);
    vecs[13] = mk(32'h30000, 1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    vecs[14] = mk(32'h30008, 1, 8'h77, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    vecs[15] = mk(32'h30001, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0);
    vecs[16] = mk(32'h30000, 1, 8'h9C, 0, 8'h00, 0, 0, 8'h00, 1, 8'h9C, 0);
    vecs[17] = mk(32'h30004, 1, 8'h12, 0, 8'h00, 0, 0, 8'h00, 1, 8'h9C, 1);
    vecs[18] = mk(32'h20000, 0, 8'h00, 0, 8'h00, 1, 1, 8'h00, 1, 8'h00, 1);
    vecs[19] = mk(32'h00010, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA5, 0, 8'h00, 1);
    vecs[20] = mk(32'h30000, 0, 8'h00, 1, 8'h55, 0, 1, 8'h00, 0, 8'h00, 1);
    vecs[21] = mk(32'h30000, 0, 8'h00, 0, 8'h00, 0, 1, 8'h55, 0, 8'h00, 1);

    repeat (2) @(negedge clk_in);
    step();
    chk("reset mem_din", mem_din, 8'h00);
    chk("reset cpu_rdy", cpu_rdy, 1'b1);
    chk("reset rx_ready", rx_ready, 1'b1);
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset finish", program_finish, 1'b0);
    rst_in = 1'b0;

    for (int i = 0; i < 22; i++) begin
      bus(vecs[i].a, vecs[i].wr, vecs[i].dout);
      rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd; tx_ready = vecs[i].txr;
      step();
      if (vecs[i].chk_din) chk($sformatf("vec%0d mem_din", i), mem_din, vecs[i].din);
      chk($sformatf("vec%0d cpu_rdy", i), cpu_rdy, vecs[i].rdy);
      chk($sformatf("vec%0d rx_ready", i), rx_ready, vecs[i].rxr);
      chk($sformatf("vec%0d tx_valid", i), tx_valid, vecs[i].txv);
      if (vecs[i].txv) chk($sformatf("vec%0d tx_data", i), tx_data, vecs[i].txd);
      chk($sformatf("vec%0d finish", i), program_finish, vecs[i].fin);
    end
    rx_valid = 0; tx_ready = 0;

    // TX back-pressure: 7 pushes drop cpu_rdy, the 8th lands in the margin slot
    for (int k = 1; k <= 8; k++) begin
      bus(32'h30000, 1, 8'(k));
      step();
      chk($sformatf("bp push%0d cpu_rdy", k), cpu_rdy, (k <= 6) ? 1'b1 : 1'b0);
    end
    chk("bp full tx_data head", tx_data, 8'h01);
    bus(32'h00010, 0, 8'h00);
    tx_ready = 1;
    drained = 0;
    for (int c = 0; c < 20 && tx_valid; c++) begin
      exp_tx = 8'(drained + 1);
      chk($sformatf("bp drain%0d tx_data", drained), tx_data, exp_tx);
      step();
      drained++;
      chk($sformatf("bp drain%0d cpu_rdy", drained), cpu_rdy, (8 - drained <= 6) ? 1'b1 : 1'b0);
    end
    chk("bp drained count", drained, 8);
    tx_ready = 0;

    // RX full: pop at full frees a slot but the offered byte is not taken
    for (int k = 0; k < 8; k++) begin
      rx_valid = 1; rx_data = 8'h10 + 8'(k);
      step();
    end
    chk("rx full rx_ready", rx_ready, 1'b0);
    rx_data = 8'hEE;
    bus(32'h30000, 0, 8'h00);
    step();
    rx_valid = 0;
    chk("rx full pop data", mem_din, 8'h10);
    chk("rx full after pop rx_ready", rx_ready, 1'b1);
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("rx drain%0d", k), mem_din, 8'h10 + 8'(k));
    end
    step();
    chk("rx empty after drain", mem_din, 8'h00);

    // Counter snapshot 300 cycles after reset release
    rst_in = 1;
    step();
    chk("rst2 finish cleared", program_finish, 1'b0);
    rst_in = 0;
    bus(32'h00010, 0, 8'h00);
    repeat (300) step();
    bus(32'h30004, 0, 8'h00); step(); assembled[7:0]   = mem_din;
    bus(32'h30005, 0, 8'h00); step(); assembled[15:8]  = mem_din;
    bus(32'h30006, 0, 8'h00); step(); assembled[23:16] = mem_din;
    bus(32'h30007, 0, 8'h00); step(); assembled[31:24] = mem_din;
    chk("cnt byte0", assembled[7:0], 8'h2C);
    chk("cnt byte1", assembled[15:8], 8'h01);
    chk("cnt assembled", assembled, 32'd300);

    // Counter wrap
    bus(32'h00010, 0, 8'h00);
    force dut.r_cycle_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_cycle_cnt;
    repeat (3) step();
    bus(32'h30004, 0, 8'h00); step(); assembled[7:0]   = mem_din;
    bus(32'h30005, 0, 8'h00); step(); assembled[15:8]  = mem_din;
    bus(32'h30006, 0, 8'h00); step(); assembled[23:16] = mem_din;
    bus(32'h30007, 0, 8'h00); step(); assembled[31:24] = mem_din;
    chk("wrap assembled", assembled, 32'h0000_0001);

    // Reset mid-burst with FIFOs populated and a read in flight
    for (int k = 0; k < 3; k++) begin
      rx_valid = 1; rx_data = 8'hC0 + 8'(k);
      bus(32'h30000, 1, 8'hD0 + 8'(k));
      step();
    end
    rx_valid = 0;
    bus(32'h00010, 0, 8'h00);
    step();
    chk("pre-reset ram read", mem_din, 8'hA5);
    chk("pre-reset tx_valid", tx_valid, 1'b1);
    rst_in = 1;
    step();
    chk("midrst mem_din", mem_din, 8'h00);
    chk("midrst tx_valid", tx_valid, 1'b0);
    chk("midrst rx_ready", rx_ready, 1'b1);
    chk("midrst cpu_rdy", cpu_rdy, 1'b1);
    rst_in = 0;
    bus(32'h30000, 0, 8'h00);
    step();
    chk("midrst rx empty", mem_din, 8'h00);
    chk("ram kept through reset", 32'(dut.r_ram[17'h00010]), 32'h0000_00A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
